pattern_tx: RTL and testbench
=============================

# pattern_tx

Serial frame transmitter that drives the single-bit stream consumed by the team's Moore `1101` pattern detector. Accepts a parallel data word over a valid/ready handshake, then emits a fixed `1101` sync preamble, the data word MSB-first, an optional parity bit, and an idle gap of zeros. It sits upstream of the detector and serves as both a stimulus source and a link transmitter.

## Interface
- DATA_W, 8, payload width in bits; legal range 1–32.
- GAP_CYCLES, 2, number of forced-zero cycles after each frame; legal range 1–15.

- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- din  input  DATA_W  payload word, sampled on handshake.
- valid  input  1  din is valid.
- ready  output  1  transmitter can accept a word; high only in IDLE.
- y  output  1  registered serial line; idle level 0.
- busy  output  1  high from the cycle after acceptance through the last gap cycle.
- frame_start  output  1  one-cycle pulse coincident with the first preamble bit on y.

## Operation
- FSM states: IDLE, PRE, DATA, PAR (present only when parity is compiled in), GAP.
- IDLE: y=0 and ready=1. On valid&&ready at a rising edge, the FSM captures din into the shift register, clears the bit counter, and moves to PRE.
- PRE: drives 1,1,0,1 over 4 cycles with a 2-bit index, then moves to DATA.
- DATA: drives din[DATA_W-1] down to din[0], one bit per cycle. After the last bit it moves to PAR if enabled, else GAP.
- PAR: one cycle; y = even parity, the XOR of all captured payload bits. Then GAP.
- GAP: y=0 for GAP_CYCLES cycles, then IDLE.
- valid is ignored outside IDLE. din is not required to be stable after the handshake.
- No bit stuffing: a payload containing `1101` will also trigger the detector. Framing above the link resolves this.
- Reset mid-frame: the frame aborts immediately, y→0, the FSM→IDLE, and the counter and shift register clear. No partial frame resumes.
- Reset values: y=0, busy=0, frame_start=0, FSM state IDLE. ready=1 as soon as reset deasserts; valid is ignored while reset is high.
- Bit counter width is $clog2 of the larger of DATA_W and GAP_CYCLES, plus 1. The counter never wraps within a state.

## Timing
- Handshake at edge N: y carries preamble bit 3 (1) from edge N+1, and frame_start is high for that cycle.
- Frame length L = 4 + DATA_W + P + GAP_CYCLES cycles, where P=1 with parity and 0 without. With defaults, L=14 without parity and 15 with.
- ready is low for L cycles. The earliest next handshake is edge N+L+1, so frames are separated by at least GAP_CYCLES+1 zero cycles; the minimum accepted interval is L+1 cycles.
- The sequence of zero gap cycles followed by preamble always drives the detector through S0 and ends in S4 on the fourth preamble bit. The detector's y therefore rises 4 cycles after frame_start.

## Configuration
- PATTERN_TX_PARITY_EN defined: the PAR state is present and one even-parity bit follows the payload.
- PATTERN_TX_PARITY_EN undefined: the PAR state and parity logic are absent and DATA goes directly to GAP.

## Structure
- The shared package pattern_tx_pkg contains the state enum, PREAMBLE = 4'b1101, and PREAMBLE_LEN = 4. The detector's bench reuses PREAMBLE from this package.
- Sub-module pattern_tx_piso is a DATA_W-bit parallel-load, MSB-first shift register with a load/shift enable and a running-parity output. The FSM and counters stay in pattern_tx.

## Test plan
- Reset, then idle for 10 cycles with valid=0 → y=0, ready=1, busy=0 on every cycle.
- DATA_W=8, no parity, din=8'hA5 → y = 1,1,0,1,1,0,1,0,0,1,0,1,0,0; frame_start on cycle 1 only; ready low for 14 cycles.
- Parity enabled, din=8'h07 → parity bit 1 after the payload; din=8'hA5 → parity bit 0; frame length 15.
- valid held high continuously with 8'h3C, then 8'hC3 → handshakes exactly 15 cycles apart (no parity). A detector connected to y asserts once per frame, 4 cycles after frame_start.
- reset asserted at the 3rd payload bit → y=0 and busy=0 asynchronously. After release: ready=1 and a fresh frame starts cleanly with preamble 1101.
- valid pulsed during busy → ignored; no second frame is emitted and the captured word is unchanged.

Source files
------------

// File: rtl/pattern_tx_pkg.sv
// Shared definitions for the pattern_tx serial frame transmitter.
// Build option: define PATTERN_TX_PARITY_EN to append an even-parity bit after the payload.
package pattern_tx_pkg;

    // Sync word; the 1101 detector's bench reuses this constant.
    localparam logic [3:0] PREAMBLE = 4'b1101;
    localparam int unsigned PREAMBLE_LEN = 4;

    // The PAR state only exists when parity is compiled in.
    typedef enum logic [2:0] {
        StIdle,
        StPre,
        StData,
`ifdef PATTERN_TX_PARITY_EN
        StPar,
`endif
        StGap
    } state_t;

    // Bit counter width: wide enough for the longer of the payload and the gap, plus one.
    function automatic int unsigned cnt_width(input int unsigned data_w,
                                              input int unsigned gap_cycles);
        int unsigned longest;
        longest = (data_w > gap_cycles) ? data_w : gap_cycles;
        return $clog2(longest) + 1;
    endfunction

endpackage

// File: rtl/pattern_tx_piso.sv
// Parallel-in, serial-out shift register for pattern_tx.
// Loads a DATA_W-bit word and presents it MSB-first on msb, one bit per shift.
// With PATTERN_TX_PARITY_EN defined, parity holds the XOR of all bits shifted out since the
// last load, which equals the even-parity bit once the whole word has been sent.
module pattern_tx_piso #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              shift,
    input  logic [DATA_W-1:0] din,
`ifdef PATTERN_TX_PARITY_EN
    output logic              parity,
`endif
    output logic              msb
);

    logic [DATA_W-1:0] sr_q;

    // Shift register: load has priority; shifting pushes zeros in at the LSB.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_q <= '0;
        end else if (load) begin
            sr_q <= din;
        end else if (shift) begin
            sr_q <= sr_q << 1;
        end
    end

    assign msb = sr_q[DATA_W-1];

`ifdef PATTERN_TX_PARITY_EN
    logic par_q;

    // Running parity of the bits already driven onto the line.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            par_q <= 1'b0;
        end else if (load) begin
            par_q <= 1'b0;
        end else if (shift) begin
            par_q <= par_q ^ sr_q[DATA_W-1];
        end
    end

    assign parity = par_q;
`endif

endmodule

// File: rtl/pattern_tx.sv
// pattern_tx: serial frame transmitter feeding the Moore 1101 pattern detector.
// Frame on y: preamble 1101, payload MSB-first, optional even-parity bit, GAP_CYCLES zeros.
// Build option: define PATTERN_TX_PARITY_EN to include the PAR state and the parity bit.
// All outputs except ready are registered, so y lags the FSM state by one cycle: a handshake
// at edge N puts the first preamble bit on y from edge N+1.
module pattern_tx
    import pattern_tx_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] din,
    input  logic              valid,
    output logic              ready,
    output logic              y,
    output logic              busy,
    output logic              frame_start
);

    localparam int unsigned CNT_W = cnt_width(DATA_W, GAP_CYCLES);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [1:0]       PRE_LAST  = 2'(PREAMBLE_LEN - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       pre_idx_q, pre_idx_d;
    logic             y_q, y_d;
    logic             busy_q, busy_d;
    logic             fs_q, fs_d;
    logic             accept;
    logic             load;
    logic             shift;
    logic             sr_msb;
`ifdef PATTERN_TX_PARITY_EN
    logic             sr_parity;
`endif

    // ready is decoded straight from the state so a word can be taken the cycle IDLE is entered;
    // holding it low during reset keeps valid from being seen while reset is high.
    assign ready  = (state_q == StIdle) && !reset;
    assign accept = valid && ready;

    pattern_tx_piso #(
        .DATA_W (DATA_W)
    ) u_piso (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .shift  (shift),
        .din    (din),
`ifdef PATTERN_TX_PARITY_EN
        .parity (sr_parity),
`endif
        .msb    (sr_msb)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StPre;
                end
            end
            StPre: begin
                if (pre_idx_q == PRE_LAST) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (cnt_q == DATA_LAST) begin
`ifdef PATTERN_TX_PARITY_EN
                    state_d = StPar;
`else
                    state_d = StGap;
`endif
                end
            end
`ifdef PATTERN_TX_PARITY_EN
            StPar: begin
                state_d = StGap;
            end
`endif
            StGap: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Counters restart on every state change, so neither ever wraps inside a state.
    always_comb begin
        cnt_d     = cnt_q;
        pre_idx_d = pre_idx_q;
        if (state_d != state_q) begin
            cnt_d     = '0;
            pre_idx_d = '0;
        end else begin
            case (state_q)
                StPre:         pre_idx_d = pre_idx_q + 2'd1;
                StData, StGap: cnt_d     = cnt_q + 1'b1;
                default:       ;
            endcase
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            pre_idx_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            pre_idx_q <= pre_idx_d;
        end
    end

    // Output decode: the bit for the current state, registered onto the line below.
    always_comb begin
        y_d    = 1'b0;
        fs_d   = 1'b0;
        busy_d = (state_q != StIdle);
        load   = 1'b0;
        shift  = 1'b0;
        case (state_q)
            StIdle: begin
                load = accept;
            end
            StPre: begin
                y_d  = PREAMBLE[PRE_LAST - pre_idx_q];
                fs_d = (pre_idx_q == 2'd0);
            end
            StData: begin
                y_d   = sr_msb;
                shift = 1'b1;
            end
`ifdef PATTERN_TX_PARITY_EN
            StPar: begin
                y_d = sr_parity;
            end
`endif
            default: ;
        endcase
    end

    // Registered line outputs; reset forces the line idle immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            y_q    <= 1'b0;
            busy_q <= 1'b0;
            fs_q   <= 1'b0;
        end else begin
            y_q    <= y_d;
            busy_q <= busy_d;
            fs_q   <= fs_d;
        end
    end

    assign y           = y_q;
    assign busy        = busy_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_pattern_tx.sv
// Self-checking bench for pattern_tx (DATA_W=8, GAP_CYCLES=2).
// Define PATTERN_TX_PARITY_EN for both bench and RTL to exercise the parity build.
module tb_pattern_tx;

    localparam int unsigned DATA_W     = 8;
    localparam int unsigned GAP_CYCLES = 2;
`ifdef PATTERN_TX_PARITY_EN
    localparam int unsigned PAR_BITS = 1;
`else
    localparam int unsigned PAR_BITS = 0;
`endif
    localparam int unsigned FRAME_LEN = 4 + DATA_W + PAR_BITS + GAP_CYCLES;

    // Expected per-cycle view of the DUT outputs.
    typedef struct packed {
        logic y;
        logic fs;
        logic busy;
        logic ready;
    } exp_t;

    // Table vector: payload and its hand-computed even-parity bit.
    typedef struct {
        logic [7:0] din;
        logic       par;
    } vec_t;

    localparam exp_t IDLE_E = '{y: 1'b0, fs: 1'b0, busy: 1'b0, ready: 1'b1};

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] din;
    logic       valid;
    logic       ready;
    logic       y;
    logic       busy;
    logic       frame_start;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t exp_q[$];
    exp_t cur_e;
    logic mon_en  = 1'b0;
    logic cur_par = 1'b0;
    logic det_en  = 1'b0;
    int   cyc      = 0;
    int   hs_count = 0;
    int   hs_cyc   = 0;
    int   fs_cyc   = 0;
    int   det_hits = 0;
    logic [2:0] det_s;
    logic det_prev = 1'b0;

    pattern_tx #(
        .DATA_W     (DATA_W),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .din         (din),
        .valid       (valid),
        .ready       (ready),
        .y           (y),
        .busy        (busy),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d at %0t", name, act, req, $time);
        end
    endfunction

    // Queue the expected output sequence of one accepted frame.
    function automatic void push_frame(input logic [7:0] d, input logic p);
        logic [3:0] pre = 4'b1101;
        logic       bits[$];
        exp_t       e;
        for (int i = 3; i >= 0; i--) bits.push_back(pre[i]);
        for (int i = 7; i >= 0; i--) bits.push_back(d[i]);
`ifdef PATTERN_TX_PARITY_EN
        bits.push_back(p);
`endif
        for (int i = 0; i < GAP_CYCLES; i++) bits.push_back(1'b0);
        // Handshake cycle itself: ready already low, line still idle.
        e = '0;
        exp_q.push_back(e);
        for (int k = 0; k < bits.size(); k++) begin
            e.y     = bits[k];
            e.fs    = (k == 0);
            e.busy  = 1'b1;
            e.ready = (k == bits.size() - 1);
            exp_q.push_back(e);
        end
    endfunction

    // Reference Moore 1101 detector on y; state 4 means pattern seen.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            det_s <= 3'd0;
        end else begin
            case (det_s)
                3'd0:    det_s <= y ? 3'd1 : 3'd0;
                3'd1:    det_s <= y ? 3'd2 : 3'd0;
                3'd2:    det_s <= y ? 3'd2 : 3'd3;
                3'd3:    det_s <= y ? 3'd4 : 3'd0;
                default: det_s <= y ? 3'd2 : 3'd0;
            endcase
        end
    end

    // Scoreboard monitor: one expected entry per cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (mon_en && !reset) begin
            cyc++;
            if (exp_q.size() > 0) cur_e = exp_q.pop_front();
            else cur_e = IDLE_E;
            check("y", y, cur_e.y);
            check("frame_start", frame_start, cur_e.fs);
            check("busy", busy, cur_e.busy);
            check("ready", ready, cur_e.ready);
            if (cur_e.ready && valid) begin
                push_frame(din, cur_par);
                hs_count++;
                hs_cyc = cyc;
            end
            if (det_en) begin
                if (frame_start) fs_cyc = cyc;
                if (det_s == 3'd4 && !det_prev) begin
                    det_hits++;
                    check("det_delay", cyc - fs_cyc, 4);
                end
            end
            det_prev = (det_s == 3'd4);
        end
    end

    task automatic wait_hs(input int target, input string name);
        int t = 0;
        while (hs_count < target && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (hs_count < target) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: no handshake within %0d cycles, got %0d required %0d",
                     name, t, hs_count, target);
        end
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        while (exp_q.size() > 0 && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (exp_q.size() > 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: %0d expected cycles still pending, required 0", name, exp_q.size());
        end
    endtask

    task automatic send(input logic [7:0] d, input logic p);
        int target;
        target  = hs_count + 1;
        din     = d;
        cur_par = p;
        valid   = 1'b1;
        wait_hs(target, "handshake");
        valid = 1'b0;
        din   = ~d;
    endtask

    initial begin
        vec_t vecs[8];
        int   start;
        int   c0;
        vecs[0] = '{din: 8'hA5, par: 1'b0};
        vecs[1] = '{din: 8'h07, par: 1'b1};
        vecs[2] = '{din: 8'h00, par: 1'b0};
        vecs[3] = '{din: 8'hFF, par: 1'b0};
        vecs[4] = '{din: 8'h80, par: 1'b1};
        vecs[5] = '{din: 8'h5A, par: 1'b0};
        vecs[6] = '{din: 8'h3C, par: 1'b0};
        vecs[7] = '{din: 8'h01, par: 1'b1};

        reset = 1'b0;
        valid = 1'b0;
        din   = 8'h00;
        #2 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_y", y, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_start", frame_start, 0);
        reset  = 1'b0;
        #1;
        check("ready_after_rst", ready, 1);
        mon_en = 1'b1;
        // Idle with valid low: the monitor checks the idle outputs each cycle.
        repeat (10) @(posedge clk);
        #1;

        // Table-driven frames.
        for (int i = 0; i < 8; i++) begin
            send(vecs[i].din, vecs[i].par);
            wait_idle("frame_drain");
            repeat (2) @(posedge clk);
            #1;
        end

        // valid held high across two words: back-to-back handshakes, one detection per frame.
        det_en   = 1'b1;
        det_hits = 0;
        start    = hs_count;
        cur_par  = 1'b0;
        din      = 8'h3C;
        valid    = 1'b1;
        wait_hs(start + 1, "b2b_first");
        c0  = hs_cyc;
        din = 8'hC3;
        wait_hs(start + 2, "b2b_second");
        valid = 1'b0;
        din   = 8'h00;
        wait_idle("b2b_drain");
        check("b2b_interval", hs_cyc - c0, FRAME_LEN + 1);
        repeat (3) @(posedge clk);
        #1;
        check("det_hits", det_hits, 2);
        det_en = 1'b0;

        // valid pulsed while busy must be ignored.
        send(8'hA5, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        din   = 8'hFF;
        valid = 1'b1;
        @(posedge clk);
        #1;
        valid = 1'b0;
        wait_idle("busy_pulse_drain");
        repeat (2) @(posedge clk);
        #1;

        // Reset during the third payload bit aborts the frame at once.
        send(8'hA5, 1'b0);
        repeat (7) @(posedge clk);
        #2;
        check("y_before_abort", y, 1);
        mon_en = 1'b0;
        reset  = 1'b1;
        #1;
        check("abort_y", y, 0);
        check("abort_busy", busy, 0);
        check("abort_frame_start", frame_start, 0);
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("abort_ready", ready, 1);
        mon_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        send(8'hC3, 1'b0);
        wait_idle("post_abort_drain");
        repeat (3) @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
